alu_wide_seq: RTL and testbench

Multi-byte arithmetic sequencer built around the 8-bit `alu`. It accepts operands up to 8*NBYTES bits wide and runs them through a single `alu` instance one byte per cycle, least-significant byte first. Carry/borrow is chained between bytes and the zero flag is accumulated across all bytes. It sits between the CPU control unit and the ALU, so 16-bit (register-pair) ADD/SUB/AND/OR/XOR ops can share the 8-bit datapath.

---
 rtl/alu_wide_seq_pkg.sv | 21 ++
 rtl/alu_wide_seq_alu.sv | 40 ++++
 rtl/alu_wide_seq.sv | 127 ++++++++++++
 tb/tb_alu_wide_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_wide_seq_pkg.sv
// Shared definitions for the wide ALU sequencer and its 8-bit ALU.
// Contents:
//   ALU_OP_*         3-bit operator codes understood by the alu
//   ALU_PASS_BYTE    byte returned by the alu for unlisted operator codes
//   alu_seq_state_e  sequencer state encoding (decodable by the control unit)
package alu_wide_seq_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;
    localparam logic [2:0] ALU_OP_AND = 3'd2;
    localparam logic [2:0] ALU_OP_OR  = 3'd3;
    localparam logic [2:0] ALU_OP_XOR = 3'd4;

    localparam logic [7:0] ALU_PASS_BYTE = 8'h71;

    typedef enum logic {
        ALU_SEQ_IDLE = 1'b0,
        ALU_SEQ_RUN  = 1'b1
    } alu_seq_state_e;

endpackage

// File: rtl/alu_wide_seq_alu.sv
// 8-bit combinational ALU.
// Ports:
//   a, b        input  8  operands
//   carry_in    input  1  carry (ADD) or borrow (SUB) in
//   operator    input  3  ALU_OP_* code
//   result      output 8  byte result
//   flag_carry  output 1  carry/borrow out of bit 7; 0 for logic ops
//   flag_zero   output 1  1 iff result == 0x00
module alu
    import alu_wide_seq_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    input  logic [2:0] operator,
    output logic [7:0] result,
    output logic       flag_carry,
    output logic       flag_zero
);

    logic [8:0] wide;

    always_comb begin
        wide = '0;
        case (operator)
            ALU_OP_ADD: wide = {1'b0, a} + {1'b0, b} + {8'b0, carry_in};
            // Bit 8 of the 9-bit difference is the borrow out.
            ALU_OP_SUB: wide = {1'b0, a} - {1'b0, b} - {8'b0, carry_in};
            ALU_OP_AND: wide = {1'b0, a & b};
            ALU_OP_OR:  wide = {1'b0, a | b};
            ALU_OP_XOR: wide = {1'b0, a ^ b};
            default:    wide = {1'b0, ALU_PASS_BYTE};
        endcase
    end

    assign result     = wide[7:0];
    assign flag_carry = wide[8];
    assign flag_zero  = (wide[7:0] == 8'h00);

endmodule

// File: rtl/alu_wide_seq.sv
// Multi-byte arithmetic sequencer: streams NBYTES-wide operands through a
// single 8-bit alu, LSB byte first, chaining carry/borrow and accumulating
// the zero flag across bytes.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        request pulse; accepted only when idle
//   operator     ALU_OP_* code, latched on start
//   carry_in     initial carry/borrow, latched on start
//   operand_a/b  8*NBYTES operands, latched on start
//   busy         high while bytes are being processed
//   done         one-cycle pulse when result/flags are valid
//   result       wide result, held until overwritten
//   flag_zero    1 iff every result byte is zero, held
//   flag_carry   carry/borrow out of the MSB byte, held
module alu_wide_seq
    import alu_wide_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            operator,
    input  logic                  carry_in,
    input  logic [8*NBYTES-1:0]   operand_a,
    input  logic [8*NBYTES-1:0]   operand_b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  flag_zero,
    output logic                  flag_carry
);

    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    alu_seq_state_e  state;
    logic [IDXW-1:0] idx;
    logic [2:0]      op_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry_reg;
    logic            zero_acc;

    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      alu_result;
    logic            alu_carry;
    logic            alu_zero;

    // Byte select mux feeding the single shared ALU.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx == i[IDXW-1:0]) begin
                a_byte = a_reg[i*8 +: 8];
                b_byte = b_reg[i*8 +: 8];
            end
        end
    end

    alu u_alu (
        .a          (a_byte),
        .b          (b_byte),
        .carry_in   (carry_reg),
        .operator   (op_reg),
        .result     (alu_result),
        .flag_carry (alu_carry),
        .flag_zero  (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ALU_SEQ_IDLE;
            idx        <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            carry_reg  <= 1'b0;
            zero_acc   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ALU_SEQ_IDLE: begin
                    if (start) begin
                        op_reg    <= operator;
                        a_reg     <= operand_a;
                        b_reg     <= operand_b;
                        carry_reg <= carry_in;
                        zero_acc  <= 1'b1;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ALU_SEQ_RUN;
                    end
                end
                ALU_SEQ_RUN: begin
                    for (int unsigned i = 0; i < NBYTES; i++) begin
                        if (idx == i[IDXW-1:0]) begin
                            result[i*8 +: 8] <= alu_result;
                        end
                    end
                    carry_reg <= alu_carry;
                    zero_acc  <= zero_acc & alu_zero;
                    if (idx == LAST_IDX) begin
                        flag_zero  <= zero_acc & alu_zero;
                        flag_carry <= alu_carry;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        idx        <= '0;
                        state      <= ALU_SEQ_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= ALU_SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed, table-driven bench for alu_wide_seq with NBYTES=2.
module tb_alu_wide_seq;

    localparam int unsigned NB = 2;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_BAD = 3'd7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    operator;
    logic          carry_in;
    logic [15:0]   operand_a;
    logic [15:0]   operand_b;
    logic          busy;
    logic          done;
    logic [15:0]   result;
    logic          flag_zero;
    logic          flag_carry;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_wide_seq #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .operator   (operator),
        .carry_in   (carry_in),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive operands at negedge; start is accepted at the next posedge.
    task automatic launch(input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic cin);
        @(negedge clk);
        operator  = op;
        operand_a = a;
        operand_b = b;
        carry_in  = cin;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called #1 after the accepting edge; returns edges until done and
    // the number of sampled cycles with busy high.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        int cyc;
        int bcnt;
        int seen;

        vecs[0] = '{OP_ADD, 16'h12FF, 16'h0001, 1'b0, 16'h1300, 1'b0, 1'b0};
        vecs[1] = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[2] = '{OP_ADD, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};
        vecs[3] = '{OP_SUB, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vecs[4] = '{OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{OP_XOR, 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[6] = '{OP_OR,  16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{OP_BAD, 16'h1234, 16'h5678, 1'b0, 16'h7171, 1'b0, 1'b0};
        vecs[8] = '{OP_AND, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0};
        vecs[9] = '{OP_SUB, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; operator = '0; carry_in = 1'b0;
        operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_zero", flag_zero, 0);
        check("reset_carry", flag_carry, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done(cyc, bcnt);
            check($sformatf("v%0d_latency", i), cyc, 2);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 2);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_carry", i), flag_carry, vecs[i].c);
            check($sformatf("v%0d_zero", i), flag_zero, vecs[i].z);
        end

        // start re-pulsed while busy must be ignored and not queued.
        launch(OP_ADD, 16'h0102, 16'h0304, 1'b0);
        @(negedge clk);
        operator = OP_SUB; operand_a = 16'hFFFF; operand_b = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        while (!done && cyc < 10) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("ignore_latency", cyc, 2);
        check("ignore_result", result, 16'h0406);
        check("ignore_carry", flag_carry, 0);
        check("ignore_zero", flag_zero, 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("no_queued_op", busy, 0);

        // start presented during the done cycle is accepted.
        launch(OP_ADD, 16'h0001, 16'h0001, 1'b0);
        wait_done(cyc, bcnt);
        check("b2b_first_result", result, 16'h0002);
        operator = OP_XOR; operand_a = 16'h00FF; operand_b = 16'h0F0F;
        carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy_after_accept", busy, 1);
        wait_done(cyc, bcnt);
        check("b2b_latency", cyc, 2);
        check("b2b_result", result, 16'h0FF0);

        // Reset mid-operation abandons the op with no done pulse.
        launch(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_zero", flag_zero, 0);
        check("midrst_carry", flag_carry, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (done || busy) seen++;
        end
        check("midrst_no_done", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
